witf_scoreboard: RTL
====================

Name: witf_scoreboard

Overview:
- Write-in-flight table (witf) for the NPC in-order pipeline.
- Records the destination register of every instruction issued from IDU to EXU until that instruction writes back.
- From the current rs1/rs2, combinationally drives the isRAW and witf_full stall inputs consumed by IDU.
- Implemented as an in-order circular FIFO of rd entries, with parallel associative match against all valid entries.

Parameters:
DEPTH, 4, number of in-flight entries; power of two, 2..16
AW, 5, register address width (RegAddrBus width)
CW, 3, occupancy counter width; must hold 0..DEPTH ($clog2(DEPTH+1))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
rs1  input  AW  source register 1 of instruction in decode
rs2  input  AW  source register 2 of instruction in decode
rs1_used  input  1  decode instruction reads rs1
rs2_used  input  1  decode instruction reads rs2
push_valid  input  1  issue of a register-writing instruction this cycle (IDU->EXU fire with RegWr_d=1)
push_rd  input  AW  rd of the issued instruction
pop_valid  input  1  writeback of the oldest register-writing instruction this cycle
pop_rd  input  AW  rd being written back (consistency check only)
isRAW  output  1  rs1 or rs2 hits a valid in-flight entry
witf_full  output  1  count == DEPTH
witf_empty  output  1  count == 0
count  output  CW  number of valid entries
err  output  1  sticky protocol error flag

Behaviour:
- Storage: DEPTH x AW rd array, DEPTH valid bits, head (oldest) and tail pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
- Reset (async, rst=1): all valid bits=0; head=tail=0; count=0; err=0. Outputs: isRAW=0, witf_full=0, witf_empty=1. The rd array is not reset.
- Push accepted when push_valid && (!witf_full || pop_valid):
  - entry[tail] <= push_rd; valid[tail] <= 1; tail <= tail+1.
- Pop accepted when pop_valid && !witf_empty:
  - valid[head] <= 0; head <= head+1.
  - If pop_rd != entry[head], set err.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Simultaneous push+pop:
  - When full: accepted, count stays DEPTH. The new entry occupies the slot just freed (tail==head).
  - When empty: the pop is illegal, so err is set and only the push takes effect (count=1).
- Push while full without pop: ignored; state unchanged; err set.
- Pop while empty (no push): ignored; err set.
- err is sticky until rst.
- isRAW (combinational, from registered state only):
  - (rs1_used && rs1!=0 && hit(rs1)) || (rs2_used && rs2!=0 && hit(rs2)).
  - hit(r) = OR over all i of valid[i] && entry[i]==r.
  - x0 never hazards. An rd=0 entry is still pushed and popped normally, which keeps ordering intact.
- Same-cycle effects on isRAW:
  - An entry being popped in the current cycle still counts as a hit; the regfile write lands at the clock edge, so this costs one conservative bubble.
  - A push in the current cycle does not affect isRAW until the next cycle.
- witf_full and witf_empty are decoded from count (combinational); no latency.
- Latency: push/pop visible in isRAW, count and flags on the cycle after the accepting edge.

Test Plan:
- Reset mid-operation: push x5,x6, assert rst between edges -> count=0, witf_empty=1, isRAW=0 immediately, err=0.
- RAW detect: push rd=7; next cycle rs1=7, rs1_used=1 -> isRAW=1. With rs1_used=0 -> isRAW=0. With rs2=7, rs2_used=1 -> isRAW=1.
- x0 ignore: push rd=0, rs1=0, rs1_used=1 -> isRAW=0, count=1. Pop with pop_rd=0 -> count=0, err=0.
- Fill and wrap (DEPTH=4):
  - Push rd 1,2,3,4 -> witf_full=1, count=4.
  - Push 9 alone -> ignored, err=1.
  - Reset, refill, then push 9 together with pop of 1 -> count=4; rs1=1 no longer hits, rs1=9 hits. Repeat 6 times to exercise pointer wrap.
- Pop same cycle as check: entry rd=3 at head, pop_valid=1 with rs1=3 -> isRAW=1 that cycle, 0 the next.
- Ordering check: push 4 then 5; pop with pop_rd=5 -> err=1, head advances, count=1; rs1=5 still hits.

Source files
------------

// File: rtl/witf_scoreboard.sv
// Write-in-flight table: in-order FIFO of destination registers for issued,
// not-yet-written-back instructions, with associative RAW match for decode.
module witf_scoreboard #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          rs1_used,
    input  logic          rs2_used,
    input  logic          push_valid,
    input  logic [AW-1:0] push_rd,
    input  logic          pop_valid,
    input  logic [AW-1:0] pop_rd,
    output logic          isRAW,
    output logic          witf_full,
    output logic          witf_empty,
    output logic [CW-1:0] count,
    output logic          err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic push_acc;
    logic pop_acc;
    logic hit1;
    logic hit2;

    assign witf_full  = (count == CW'(DEPTH));
    assign witf_empty = (count == '0);

    // A pop frees the head slot in the same edge, so a full table can still take a push.
    assign push_acc = push_valid && (!witf_full || pop_valid);
    assign pop_acc  = pop_valid && !witf_empty;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i] == rs1) hit1 = 1'b1;
            if (valid[i] && entries[i] == rs2) hit2 = 1'b1;
        end
    end

    assign isRAW = (rs1_used && rs1 != '0 && hit1) || (rs2_used && rs2 != '0 && hit2);

    always_ff @(posedge clk) begin
        if (push_acc) entries[tail] <= push_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            // Push is applied after pop so a full push+pop leaves the reused slot valid.
            if (pop_acc) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            if (push_acc) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (push_acc && !pop_acc)      count <= count + 1'b1;
            else if (pop_acc && !push_acc) count <= count - 1'b1;

            if ((pop_valid && witf_empty) ||
                (push_valid && witf_full && !pop_valid) ||
                (pop_acc && pop_rd != entries[head]))
                err <= 1'b1;
        end
    end
endmodule
